time_set_controller: RTL
========================

# time_set_controller

Sequencing controller for the digital clock's BCD time counters (hour, minute, second). It replaces clock-muxing for set mode with single-clock enable pulses: in RUN it forwards the 1 Hz tick to the second counter. In the set states it walks the user through hour → minute → second editing from two push-buttons, with auto-repeat, display blink and an inactivity timeout. It sits between the key/tick generators and the counter chain.

## Interface
- REPEAT_DELAY, 4: tick_fast periods a held key_inc must stay pressed before auto-repeat starts.
- TIMEOUT_S, 30: tick_1hz periods without a key press before a set state returns to RUN (≥1).
- clock  input  1  system clock; only clock in the block.
- reset  input  1  synchronous, active-low reset.
- tick_1hz  input  1  one-cycle pulse, 1 Hz.
- tick_fast  input  1  one-cycle pulse, 4 Hz nominal; drives repeat and blink.
- key_mode  input  1  raw push-button, active-low, asynchronous.
- key_inc  input  1  raw push-button, active-low, asynchronous.
- sec_inc  output  1  one-cycle increment enable to second counter.
- min_inc  output  1  one-cycle increment enable to minute counter.
- hour_inc  output  1  one-cycle increment enable to hour counter.
- sec_clear  output  1  one-cycle synchronous clear to second counter.
- carry_inhibit  output  1  high in all set states; downstream gates inter-counter carries.
- field_sel  output  2  0 = none (RUN), 1 = hour, 2 = minute, 3 = second.
- blink  output  1  display-enable for the selected field.

## Operation
- Keys pass through a 2-flop synchronizer, then a falling-edge detector producing a one-cycle press pulse (mode_p, inc_p).
- FSM states: RUN, SET_HOUR, SET_MIN, SET_SEC.
  - mode_p transitions: RUN→SET_HOUR→SET_MIN→SET_SEC→RUN.
  - A timeout in any set state goes to RUN.
- RUN:
  - sec_inc = registered tick_1hz.
  - carry_inhibit = 0, field_sel = 0, blink = 1.
  - key_inc is ignored.
- SET_HOUR / SET_MIN:
  - tick_1hz is suppressed, so time is frozen.
  - Each inc event pulses hour_inc or min_inc for one cycle.
- SET_SEC: each inc event pulses sec_clear (not sec_inc).
- Inc events:
  - one on inc_p;
  - then, while key_inc is held, a repeat counter counts tick_fast;
  - when it reaches REPEAT_DELAY, one event fires on every subsequent tick_fast until release.
  - Release clears the repeat counter.
- Timeout counter, width clog2(TIMEOUT_S+1):
  - cleared on any press pulse and on entry to a set state;
  - increments on tick_1hz in set states;
  - reaching TIMEOUT_S forces RUN next cycle.
- Blink in set states: toggles on each tick_fast; forced to 1 on every inc event and on state entry.
- Simultaneous events:
  - mode_p and an inc event in the same cycle: mode wins and the inc event is dropped.
  - timeout and mode_p in the same cycle: RUN.
  - tick_1hz coinciding with the transition SET_SEC→RUN: not forwarded; the first forwarded tick is the next one.
- At most one of sec_inc/min_inc/hour_inc/sec_clear is high in any cycle.

## Timing
- All outputs are registered.
- Reset values: state RUN, sec_inc = min_inc = hour_inc = sec_clear = 0, carry_inhibit = 0, field_sel = 0, blink = 1; synchronizers and counters cleared.
- Synchronizers reset to 1 (released) so that no press is seen after reset.
- Key latency: a key first sampled low at edge k produces its press pulse during cycle k+2. Output/state effects are visible after edge k+3.
- tick_1hz → sec_inc: 1 cycle in RUN.
- Reset asserted mid-operation (any state, key held): next edge yields reset values.
  - A key still held at reset release produces no press until it is released and pressed again.
- State changes and field_sel/carry_inhibit updates occur on the same edge.

## Structure
- Shared package time_ctrl_pkg:
  - state encoding constants (RUN = 0, SET_HOUR = 1, SET_MIN = 2, SET_SEC = 3);
  - field_sel codes.
  - Reused by the display-blink mux and the counter wrappers.
- Sub-module key_press_detect (synchronizer + falling-edge pulse, reset value 1), instantiated for key_mode and key_inc.
- The FSM, repeat counter, timeout counter and blink stay in the top.

## Test plan
- Reset, then 3 tick_1hz pulses in RUN → exactly 3 sec_inc pulses, each 1 cycle after its tick; field_sel = 0, blink = 1.
- Four key_mode presses → field_sel 1, 2, 3, 0; carry_inhibit high only for the first three; tick_1hz is ignored while carry_inhibit is high.
- SET_MIN, key_inc held for REPEAT_DELAY+3 tick_fast periods (REPEAT_DELAY = 4) → 4 min_inc pulses (1 on press + 3 repeats); zero hour_inc/sec_inc.
- SET_SEC, one key_inc press → exactly one sec_clear pulse, zero sec_inc.
- SET_HOUR with no presses for TIMEOUT_S = 5 tick_1hz pulses → RUN one cycle after the 5th tick. A press at tick 4 restarts the count.
- key_mode and key_inc pressed in the same cycle in SET_HOUR → SET_MIN, zero hour_inc. Reset asserted while key_inc is held → reset values, and no pulse after release of reset until the key is re-pressed.

Source files
------------

// File: rtl/time_ctrl_pkg.sv
`default_nettype none
//============================================================================
// Module      : time_ctrl_pkg
// Description : Shared encodings for the time-set sequencing logic. The
//               controller state codes double as the field_sel codes, so
//               the display blink mux and the counter wrappers decode the
//               same values.
// Revision    : 1.0 - initial release
//============================================================================
package time_ctrl_pkg;

    // Controller state encoding
    localparam logic [1:0] c_st_run      = 2'd0;
    localparam logic [1:0] c_st_set_hour = 2'd1;
    localparam logic [1:0] c_st_set_min  = 2'd2;
    localparam logic [1:0] c_st_set_sec  = 2'd3;

    // field_sel codes presented to the display / counter wrappers
    localparam logic [1:0] c_field_none = 2'd0;
    localparam logic [1:0] c_field_hour = 2'd1;
    localparam logic [1:0] c_field_min  = 2'd2;
    localparam logic [1:0] c_field_sec  = 2'd3;

    // Field being edited in a given controller state
    function automatic logic [1:0] field_of_state(input logic [1:0] state);
        logic [1:0] field;
        case (state)
            c_st_set_hour: field = c_field_hour;
            c_st_set_min:  field = c_field_min;
            c_st_set_sec:  field = c_field_sec;
            default:       field = c_field_none;
        endcase
        return field;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_press_detect.sv
`default_nettype none
//============================================================================
// Module      : key_press_detect
// Description : Two-flop synchronizer plus registered falling-edge detector
//               for an active-low push-button.
//   clock      in  system clock
//   reset      in  synchronous, active-low reset
//   i_key      in  raw active-low button (asynchronous)
//   o_press    out one-cycle press pulse, two cycles after first low sample
//   o_released out synchronized key level (1 = released)
// Revision    : 1.0 - initial release
//============================================================================
module key_press_detect (
    input  logic clock,
    input  logic reset,
    input  logic i_key,
    output logic o_press,
    output logic o_released
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_sync2_d;
    logic [1:0] r_fill;
    logic       r_armed;
    logic       r_press;

    // r_fill marks when r_sync2 reflects the real pin after reset. The
    // detector only arms once the key has been seen released, so a key
    // still held at reset release never yields a press.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_sync2_d <= 1'b1;
            r_fill    <= 2'b00;
            r_armed   <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_sync1   <= i_key;
            r_sync2   <= r_sync1;
            r_sync2_d <= r_sync2;
            r_fill    <= {r_fill[0], 1'b1};
            if (r_fill[1] && r_sync2) begin
                r_armed <= 1'b1;
            end
            r_press   <= r_armed && r_sync2_d && !r_sync2;
        end
    end

    assign o_press    = r_press;
    assign o_released = r_sync2;

endmodule
`default_nettype wire

// File: rtl/time_set_controller.sv
`default_nettype none
//============================================================================
// Module      : time_set_controller
// Description : Sequences the BCD time counters between RUN (1 Hz tick
//               forwarded to seconds) and hour/minute/second set modes driven
//               by two push-buttons, with auto-repeat, blink and timeout.
//   clock, reset          system clock, synchronous active-low reset
//   tick_1hz, tick_fast   one-cycle timing pulses (1 Hz, ~4 Hz)
//   key_mode, key_inc     raw active-low push-buttons
//   sec_inc/min_inc/hour_inc/sec_clear  one-cycle counter enables
//   carry_inhibit         high while any field is being set
//   field_sel             0 none, 1 hour, 2 minute, 3 second
//   blink                 display enable for the selected field
// Revision    : 1.0 - initial release
//============================================================================
module time_set_controller
    import time_ctrl_pkg::*;
#(
    parameter int REPEAT_DELAY = 4,
    parameter int TIMEOUT_S    = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       tick_fast,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic       sec_inc,
    output logic       min_inc,
    output logic       hour_inc,
    output logic       sec_clear,
    output logic       carry_inhibit,
    output logic [1:0] field_sel,
    output logic       blink
);

    localparam int unsigned c_rep_w = (REPEAT_DELAY < 1) ? 1 : $clog2(REPEAT_DELAY + 1);
    localparam int unsigned c_to_w  = $clog2(TIMEOUT_S + 1);
    localparam logic [c_rep_w-1:0] c_rep_max = c_rep_w'(REPEAT_DELAY);
    localparam logic [c_to_w-1:0]  c_to_last = c_to_w'(TIMEOUT_S - 1);

    logic w_mode_p;
    logic w_inc_p;
    logic w_inc_released;
    logic w_unused_mode_level;

    key_press_detect u_mode_key (
        .clock      (clock),
        .reset      (reset),
        .i_key      (key_mode),
        .o_press    (w_mode_p),
        .o_released (w_unused_mode_level)
    );

    key_press_detect u_inc_key (
        .clock      (clock),
        .reset      (reset),
        .i_key      (key_inc),
        .o_press    (w_inc_p),
        .o_released (w_inc_released)
    );

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_rep_active;
    logic [c_rep_w-1:0] r_rep_cnt;
    logic [c_to_w-1:0]  r_to_cnt;
    logic               r_sec_inc;
    logic               r_min_inc;
    logic               r_hour_inc;
    logic               r_sec_clear;
    logic               r_carry_inhibit;
    logic [1:0]         r_field_sel;
    logic               r_blink;

    logic w_in_set;
    logic w_timeout;
    logic w_rep_fire;
    logic w_inc_evt;
    logic w_entering;

    assign w_in_set   = (r_state != c_st_run);
    // The tick that would make the count reach TIMEOUT_S returns to RUN on
    // the same edge that would have stored it.
    assign w_timeout  = w_in_set && tick_1hz && (r_to_cnt == c_to_last);
    assign w_rep_fire = r_rep_active && !w_inc_released && tick_fast &&
                        (r_rep_cnt == c_rep_max);
    assign w_entering = (w_state_nxt != r_state);

    // Next state and increment event; timeout beats mode, mode beats inc.
    always_comb begin
        w_state_nxt = r_state;
        w_inc_evt   = 1'b0;
        if (w_timeout) begin
            w_state_nxt = c_st_run;
        end else if (w_mode_p) begin
            case (r_state)
                c_st_run:      w_state_nxt = c_st_set_hour;
                c_st_set_hour: w_state_nxt = c_st_set_min;
                c_st_set_min:  w_state_nxt = c_st_set_sec;
                default:       w_state_nxt = c_st_run;
            endcase
        end else if (w_in_set) begin
            w_inc_evt = w_inc_p || w_rep_fire;
        end
    end

    // Auto-repeat tracking: armed by the press pulse, counts tick_fast up to
    // REPEAT_DELAY and then holds there so every later tick fires.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rep_active <= 1'b0;
            r_rep_cnt    <= '0;
        end else if (w_inc_released) begin
            r_rep_active <= 1'b0;
            r_rep_cnt    <= '0;
        end else begin
            if (w_inc_p) begin
                r_rep_active <= 1'b1;
            end
            if (r_rep_active && tick_fast && (r_rep_cnt != c_rep_max)) begin
                r_rep_cnt <= r_rep_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state         <= c_st_run;
            r_to_cnt        <= '0;
            r_sec_inc       <= 1'b0;
            r_min_inc       <= 1'b0;
            r_hour_inc      <= 1'b0;
            r_sec_clear     <= 1'b0;
            r_carry_inhibit <= 1'b0;
            r_field_sel     <= c_field_none;
            r_blink         <= 1'b1;
        end else begin
            r_state         <= w_state_nxt;
            r_carry_inhibit <= (w_state_nxt != c_st_run);
            r_field_sel     <= field_of_state(w_state_nxt);

            // Only forward ticks seen while already in RUN, so a tick on the
            // exit edge from a set state is swallowed.
            r_sec_inc   <= (r_state == c_st_run) && tick_1hz;
            r_hour_inc  <= w_inc_evt && (r_state == c_st_set_hour);
            r_min_inc   <= w_inc_evt && (r_state == c_st_set_min);
            r_sec_clear <= w_inc_evt && (r_state == c_st_set_sec);

            if ((w_state_nxt == c_st_run) || w_entering || w_mode_p || w_inc_p) begin
                r_to_cnt <= '0;
            end else if (tick_1hz) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if ((w_state_nxt == c_st_run) || w_entering || w_inc_evt) begin
                r_blink <= 1'b1;
            end else if (tick_fast) begin
                r_blink <= ~r_blink;
            end
        end
    end

    assign sec_inc       = r_sec_inc;
    assign min_inc       = r_min_inc;
    assign hour_inc      = r_hour_inc;
    assign sec_clear     = r_sec_clear;
    assign carry_inhibit = r_carry_inhibit;
    assign field_sel     = r_field_sel;
    assign blink         = r_blink;

endmodule
`default_nettype wire
